// File: rtl/e_pkg.sv
// Shared definitions for the e_walk run-walker: FSM state type and legal width range.
package e_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } e_state_t;

  localparam int unsigned E_W_MIN = 2;
  localparam int unsigned E_W_MAX = 64;

endpackage

// File: rtl/e_walk_find.sv
// Combinational run finder: from a one-hot start, walk down a run of ones to its
// terminating zero, and report the next set bit below that zero.
module e_walk_find
  import e_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_sel,
  output logic         o_hit,
  output logic [W-1:0] o_y,
  output logic [W-1:0] o_nxt
);

  logic         w_onehot;
  logic         w_act;
  logic         w_found;
  logic         w_past;
  logic         w_nf;
  logic [W-1:0] w_y;
  logic [W-1:0] w_nxt;

  assign w_onehot = (i_sel != '0) && ((i_sel & (i_sel - 1'b1)) == '0);

  // Single MSB-first pass: a start arms the walk, the first zero below it is the
  // result, and the first one below that result is the next start.
  always_comb begin
    w_y     = '0;
    w_nxt   = '0;
    w_act   = 1'b0;
    w_found = 1'b0;
    w_past  = 1'b0;
    w_nf    = 1'b0;
    for (int unsigned n = 0; n < W; n++) begin
      if (w_past && !w_nf && i_x[W-1-n]) begin
        w_nxt[W-1-n] = 1'b1;
        w_nf         = 1'b1;
      end
      if (w_act && !w_found && !i_x[W-1-n]) begin
        w_y[W-1-n] = 1'b1;
        w_found    = 1'b1;
        w_past     = 1'b1;
      end
      if (i_sel[W-1-n] && i_x[W-1-n]) begin
        w_act = 1'b1;
      end
    end
  end

  assign o_hit = w_found && w_onehot;
  assign o_y   = w_onehot ? w_y   : '0;
  assign o_nxt = w_onehot ? w_nxt : '0;

endmodule

// File: rtl/e_walk.sv
// Run-walker top: accepts a search command and streams one or all run results.
// Optional macro E_WALK_CNT_EN adds rsp_cnt_o, the 1-based hit index.
module e_walk
  import e_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         cmd_vld_i,
  output logic         cmd_rdy_o,
  input  logic [W-1:0] cmd_x_i,
  input  logic [W-1:0] cmd_sel_i,
  input  logic         cmd_all_i,
  output logic         rsp_vld_o,
  input  logic         rsp_rdy_i,
  output logic         rsp_hit_o,
  output logic [W-1:0] rsp_y_o,
`ifdef E_WALK_CNT_EN
  output logic [$clog2(W):0] rsp_cnt_o,
`endif
  output logic         rsp_last_o
);

  generate
    if (W < E_W_MIN || W > E_W_MAX) begin : g_bad_w
      $error("e_walk: W out of legal range");
    end
  endgenerate

  e_state_t     r_state;
  logic [W-1:0] r_x;
  logic [W-1:0] r_sel;
  logic         r_all;

  logic         w_hit;
  logic [W-1:0] w_y;
  logic [W-1:0] w_nxt;
  logic         w_la_hit;
  logic [W-1:0] w_la_y;
  logic [W-1:0] w_la_nxt;
  logic         w_unused_la;
  logic         w_last;
  logic         w_busy;

  e_walk_find #(.W(W)) u_cur (
    .i_x   (r_x),
    .i_sel (r_sel),
    .o_hit (w_hit),
    .o_y   (w_y),
    .o_nxt (w_nxt)
  );

  // Lookahead decides rsp_last_o now, so a following miss is never emitted.
  e_walk_find #(.W(W)) u_la (
    .i_x   (r_x),
    .i_sel (w_nxt),
    .o_hit (w_la_hit),
    .o_y   (w_la_y),
    .o_nxt (w_la_nxt)
  );

  assign w_unused_la = ^{w_la_y, w_la_nxt};
  assign w_busy      = (r_state == BUSY);
  assign w_last      = !w_hit || !r_all || !w_la_hit;

  assign cmd_rdy_o  = (r_state == IDLE);
  assign rsp_vld_o  = w_busy;
  assign rsp_hit_o  = w_busy && w_hit;
  assign rsp_y_o    = w_busy ? w_y : '0;
  assign rsp_last_o = w_busy && w_last;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_sel   <= '0;
      r_all   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_vld_i) begin
            r_x     <= cmd_x_i;
            r_sel   <= cmd_sel_i;
            r_all   <= cmd_all_i;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (rsp_rdy_i) begin
            if (w_last) r_state <= IDLE;
            else        r_sel   <= w_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef E_WALK_CNT_EN
  logic [$clog2(W):0] r_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (cmd_vld_i && cmd_rdy_o) begin
      r_cnt <= 1'b1;
    end else if (w_busy && rsp_rdy_i && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rsp_cnt_o = rsp_hit_o ? r_cnt : '0;
`endif

endmodule

// File: tb/tb_e_walk.sv
// Self-checking bench for e_walk (W=8): directed cases plus random commands
// checked against a list-based model of the run-walk rules.
module tb_e_walk;

  localparam int unsigned W = 8;

  typedef struct {
    logic         hit;
    logic [W-1:0] y;
    logic         last;
    int           cnt;
  } rsp_t;

  logic         clk;
  logic         arst_n;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [W-1:0] cmd_x;
  logic [W-1:0] cmd_sel;
  logic         cmd_all;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic         rsp_hit;
  logic [W-1:0] rsp_y;
  logic         rsp_last;
`ifdef E_WALK_CNT_EN
  logic [$clog2(W):0] rsp_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  e_walk #(.W(W)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cmd_vld_i  (cmd_vld),
    .cmd_rdy_o  (cmd_rdy),
    .cmd_x_i    (cmd_x),
    .cmd_sel_i  (cmd_sel),
    .cmd_all_i  (cmd_all),
    .rsp_vld_o  (rsp_vld),
    .rsp_rdy_i  (rsp_rdy),
    .rsp_hit_o  (rsp_hit),
    .rsp_y_o    (rsp_y),
`ifdef E_WALK_CNT_EN
    .rsp_cnt_o  (rsp_cnt),
`endif
    .rsp_last_o (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: list every run end reachable from the start, keep one or all.
  task automatic build_exp(input logic [W-1:0] x, input logic [W-1:0] sel, input logic all);
    int   hits[$];
    int   s, j, k;
    rsp_t r;
    exp_q.delete();
    if ($countones(sel) == 1) begin
      s = 0;
      for (int i = 0; i < int'(W); i++) if (sel[i]) s = i;
      forever begin
        if (!x[s]) break;
        j = s - 1;
        while (j >= 0 && x[j]) j--;
        if (j < 0) break;
        hits.push_back(j);
        if (!all) break;
        k = j - 1;
        while (k >= 0 && !x[k]) k--;
        if (k < 0) break;
        s = k;
      end
    end
    if (hits.size() == 0) begin
      r.hit = 1'b0; r.y = '0; r.last = 1'b1; r.cnt = 0;
      exp_q.push_back(r);
    end else begin
      for (int i = 0; i < hits.size(); i++) begin
        r.hit  = 1'b1;
        r.y    = '0;
        r.y[hits[i]] = 1'b1;
        r.last = (i == hits.size() - 1);
        r.cnt  = i + 1;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic check_rsp(input rsp_t e);
    chk("rsp_vld", rsp_vld, 1);
    chk("rsp_hit", rsp_hit, e.hit);
    chk("rsp_y", rsp_y, e.y);
    chk("rsp_last", rsp_last, e.last);
    chk("cmd_rdy_busy", cmd_rdy, 0);
`ifdef E_WALK_CNT_EN
    chk("rsp_cnt", rsp_cnt, e.cnt);
`endif
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] sel, input logic all);
    int guard;
    guard = 0;
    while (!cmd_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_rdy_idle", cmd_rdy, 1);
    cmd_x = x; cmd_sel = sel; cmd_all = all; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    build_exp(x, sel, all);
  endtask

  task automatic run_cmd(input logic [W-1:0] x, input logic [W-1:0] sel, input logic all,
                         input int stall);
    issue(x, sel, all);
    foreach (exp_q[i]) begin
      for (int c = 0; c <= stall; c++) begin
        check_rsp(exp_q[i]);
        rsp_rdy = (c == stall);
        @(negedge clk);
      end
      rsp_rdy = 1'b0;
    end
    chk("rsp_vld_done", rsp_vld, 0);
    chk("cmd_rdy_done", cmd_rdy, 1);
  endtask

  initial begin
    logic [W-1:0] rx, rs;
    arst_n = 1'b0; cmd_vld = 1'b0; cmd_x = '0; cmd_sel = '0; cmd_all = 1'b0; rsp_rdy = 1'b0;
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_last", rsp_last, 0);
`ifdef E_WALK_CNT_EN
    chk("rst_rsp_cnt", rsp_cnt, 0);
`endif
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    run_cmd(8'b11100110, 8'b10000000, 1'b0, 0);
    run_cmd(8'b11100110, 8'b10000000, 1'b1, 0);
    run_cmd(8'b11100011, 8'b10000000, 1'b1, 0);
    run_cmd(8'b11111111, 8'b10000000, 1'b1, 0);
    run_cmd(8'b11100110, 8'b00000011, 1'b1, 0);
    run_cmd(8'b11100110, 8'b00000000, 1'b0, 0);
    run_cmd(8'b11100110, 8'b10000000, 1'b1, 3);
    run_cmd(8'b10101010, 8'b10000000, 1'b1, 1);
    run_cmd(8'b01010101, 8'b00000001, 1'b1, 0);

    // Reset between the first and second responses of an enumeration.
    issue(8'b11100110, 8'b10000000, 1'b1);
    check_rsp(exp_q[0]);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_vld", rsp_vld, 0);
    chk("mid_rst_rdy", cmd_rdy, 1);
    chk("mid_rst_hit", rsp_hit, 0);
    chk("mid_rst_y", rsp_y, 0);
    chk("mid_rst_last", rsp_last, 0);
    @(negedge clk);
    arst_n = 1'b1;
    run_cmd(8'b11100110, 8'b10000000, 1'b1, 0);

    for (int n = 0; n < 60; n++) begin
      rx = W'($urandom);
      if ($urandom_range(0, 7) == 0) rs = W'($urandom);
      else                           rs = W'(1) << $urandom_range(0, W - 1);
      run_cmd(rx, rs, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
